// File: rtl/alu_ctrl_muldiv_if.sv
// Execute-stage bundle between the pipeline and the ALU controller / mul-div unit.
// The pipeline is the master; alu_ctrl_muldiv is the slave.
interface alu_ctrl_muldiv_if #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 3,
   parameter int CTRL_W  = 4
);
   logic               valid_i;
   logic [ALUOP_W-1:0] ALUOp_i;
   logic [5:0]         funct_i;
   logic [DATA_W-1:0]  rs_data_i;
   logic [DATA_W-1:0]  rt_data_i;
   logic [CTRL_W-1:0]  ALUCtrl_o;
   logic [1:0]         hilo_sel_o;
   logic               stall_o;
   logic               busy_o;
   logic               done_o;
   logic               div_zero_o;
   logic [DATA_W-1:0]  hi_o;
   logic [DATA_W-1:0]  lo_o;

   modport master (
      output valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i,
      input  ALUCtrl_o, hilo_sel_o, stall_o, busy_o, done_o, div_zero_o, hi_o, lo_o
   );
   modport slave (
      input  valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i,
      output ALUCtrl_o, hilo_sel_o, stall_o, busy_o, done_o, div_zero_o, hi_o, lo_o
   );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// MIPS execute-stage ALU control decoder with an iterative signed/unsigned mul/div
// sequencer (IDLE -> RUN x DATA_W -> FIX) owning the HI/LO registers.
module alu_ctrl_muldiv #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 3,
   parameter int CTRL_W  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_ctrl_muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(3);
   localparam logic [CTRL_W-1:0] C_SRLV= CTRL_W'(4);
   localparam logic [CTRL_W-1:0] C_LUI = CTRL_W'(5);
   localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(6);
   localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(7);
   localparam logic [CTRL_W-1:0] C_NOR = CTRL_W'(12);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
   logic                is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic                done_q, done_d, dzp_q, dzp_d;
   logic                r_type, md_op, hilo_op, busy, stall;
   logic [CTRL_W-1:0]   alu_ctrl;
   logic [1:0]          hilo_sel;
   logic                sgn, rs_neg, rt_neg;
   logic [DATA_W-1:0]   rs_abs, rt_abs, quo, rem;
   logic [DATA_W:0]     mul_sum, div_sh, div_diff;

   assign r_type  = (bus.ALUOp_i == '0);
   assign md_op   = bus.valid_i & r_type & (bus.funct_i[5:2] == 4'b0110);
   assign hilo_op = bus.valid_i & r_type & (bus.funct_i[5:2] == 4'b0100);

   always_comb begin
      alu_ctrl = C_ADD;
      hilo_sel = 2'b00;
      if (r_type) begin
         case (bus.funct_i)
            6'd34:   alu_ctrl = C_SUB;
            6'd36:   alu_ctrl = C_AND;
            6'd37:   alu_ctrl = C_OR;
            6'd39:   alu_ctrl = C_NOR;
            6'd42:   alu_ctrl = C_SLT;
            6'd2:    alu_ctrl = C_SRL;
            6'd6:    alu_ctrl = C_SRLV;
            default: alu_ctrl = C_ADD;
         endcase
         if (bus.funct_i == 6'd16) hilo_sel = 2'b01;
         if (bus.funct_i == 6'd18) hilo_sel = 2'b10;
      end else begin
         case (bus.ALUOp_i)
            ALUOP_W'(2), ALUOP_W'(6): alu_ctrl = C_SUB;
            ALUOP_W'(3):              alu_ctrl = C_SLT;
            ALUOP_W'(4):              alu_ctrl = C_LUI;
            ALUOP_W'(5):              alu_ctrl = C_OR;
            default:                  alu_ctrl = C_ADD;
         endcase
      end
   end

   // FSM: state register / next state / outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (md_op) state_d = S_RUN;
         S_RUN:   if (cnt_nxt == CNT_W'(DATA_W)) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy           = (state_q != S_IDLE);
      stall          = busy & (md_op | hilo_op);
      bus.ALUCtrl_o  = alu_ctrl;
      bus.hilo_sel_o = hilo_sel;
      bus.stall_o    = stall;
      bus.busy_o     = busy;
      bus.done_o     = done_q;
      bus.div_zero_o = dzp_q;
      bus.hi_o       = hi_q;
      bus.lo_o       = lo_q;
   end

   // Datapath: acc holds {partial product, multiplier} or {remainder, quotient}
   always_comb begin
      sgn      = ~bus.funct_i[0];
      rs_neg   = sgn & bus.rs_data_i[DATA_W-1];
      rt_neg   = sgn & bus.rt_data_i[DATA_W-1];
      rs_abs   = rs_neg ? -bus.rs_data_i : bus.rs_data_i;
      rt_abs   = rt_neg ? -bus.rt_data_i : bus.rt_data_i;
      quo      = acc_q[DATA_W-1:0];
      rem      = acc_q[2*DATA_W-1:DATA_W];
      mul_sum  = {1'b0, rem} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_sh   = {rem, quo[DATA_W-1]};
      div_diff = div_sh - {1'b0, opnd_q};
      cnt_nxt  = cnt_q + CNT_W'(1);
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dzp_d    = 1'b0;
      case (state_q)
         S_IDLE: if (md_op) begin
            is_div_d = bus.funct_i[1];
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = rs_neg;
            dz_d     = bus.funct_i[1] & (bus.rt_data_i == '0);
            opnd_d   = bus.funct_i[1] ? rt_abs : rs_abs;
            acc_d    = {{DATA_W{1'b0}}, (bus.funct_i[1] ? rs_abs : rt_abs)};
            cnt_d    = '0;
         end
         S_RUN: begin
            cnt_d = cnt_nxt;
            if (!is_div_q)       acc_d = {mul_sum, quo[DATA_W-1:1]};
            else if (div_diff[DATA_W]) acc_d = {div_sh[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
            else                 acc_d = {div_diff[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
         end
         S_FIX: begin
            done_d = 1'b1;
            dzp_d  = dz_q;
            // divide by zero leaves rem = |rs|, so the sign fix-up restores raw rs in HI
            if (is_div_q) begin
               lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
               hi_d = rneg_q ? -rem : rem;
            end else begin
               {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
            end
         end
         default: ;
      endcase
      if (bus.valid_i && r_type && !stall) begin
         if (bus.funct_i == 6'd17) hi_d = bus.rs_data_i;
         if (bus.funct_i == 6'd19) lo_d = bus.rs_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dzp_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dzp_q    <= dzp_d;
      end
   end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv: behavioural model (countdown + plain arithmetic) checked every
// cycle, directed scenarios with literal expectations, then randomized instruction traffic.
module tb_alu_ctrl_muldiv;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_ctrl_muldiv_if #(.DATA_W(W), .ALUOP_W(3), .CTRL_W(4)) bus ();
   alu_ctrl_muldiv #(.DATA_W(W), .ALUOP_W(3), .CTRL_W(4)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // literal checks posted by the stimulus, evaluated by the compare process
   string       pin_nm [8];
   logic [63:0] pin_act[8];
   logic [63:0] pin_exp[8];
   int          pin_n = 0;

   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int          m_left = 0;
   bit          m_done = 0, m_dz = 0, p_dz = 0, m_ok = 0;

   function automatic logic [3:0] ref_ctrl(input logic [2:0] op, input logic [5:0] f);
      logic [3:0] tbl [8];
      tbl = '{4'd2, 4'd2, 4'd6, 4'd7, 4'd5, 4'd1, 4'd6, 4'd2};
      if (op != 3'd0) return tbl[op];
      case (f)
         6'd32: return 4'd2;   6'd34: return 4'd6;  6'd36: return 4'd0;
         6'd37: return 4'd1;   6'd39: return 4'd12; 6'd42: return 4'd7;
         6'd2:  return 4'd3;   6'd6:  return 4'd4;
         default: return 4'd2;
      endcase
   endfunction

   function automatic logic [64:0] ref_md(input logic [5:0] f, input logic [31:0] a, b);
      longint ps;
      logic [63:0] pu;
      int ia, ib;
      ia = a;
      ib = b;
      ref_md = '0;
      case (f)
         6'd24: begin ps = longint'(ia) * longint'(ib); ref_md = {1'b0, ps}; end
         6'd25: begin pu = {32'b0, a} * {32'b0, b}; ref_md = {1'b0, pu}; end
         6'd26: begin
            if (b == 0) ref_md = {1'b1, a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_md = {1'b0, 32'h0, 32'h8000_0000};
            else ref_md = {1'b0, 32'(ia % ib), 32'(ia / ib)};
         end
         default: begin
            if (b == 0) ref_md = {1'b1, a, 32'hFFFF_FFFF};
            else ref_md = {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   function automatic bit is_md(input logic v, input logic [2:0] op, input logic [5:0] f);
      return v && op == 3'd0 && f >= 6'd24 && f <= 6'd27;
   endfunction
   function automatic bit is_hl(input logic v, input logic [2:0] op, input logic [5:0] f);
      return v && op == 3'd0 && f >= 6'd16 && f <= 6'd19;
   endfunction

   // model: an accepted mul/div keeps the unit busy DATA_W+1 cycles, results land at the end
   initial forever begin
      int lb;
      logic [64:0] r;
      @(posedge clk);
      if (rst) begin
         m_hi = '0; m_lo = '0; m_left = 0; m_done = 0; m_dz = 0; m_ok = 1;
      end else begin
         lb = m_left;
         m_done = 0;
         m_dz = 0;
         if (lb > 0) begin
            m_left = lb - 1;
            if (m_left == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dz = p_dz;
            end
         end else if (is_md(bus.valid_i, bus.ALUOp_i, bus.funct_i)) begin
            r = ref_md(bus.funct_i, bus.rs_data_i, bus.rt_data_i);
            p_dz = r[64]; p_hi = r[63:32]; p_lo = r[31:0];
            m_left = W + 1;
         end
         if (lb == 0 && bus.valid_i && bus.ALUOp_i == 3'd0) begin
            if (bus.funct_i == 6'd17) m_hi = bus.rs_data_i;
            if (bus.funct_i == 6'd19) m_lo = bus.rs_data_i;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      logic [1:0] sel;
      bit st;
      @(negedge clk);
      if (m_ok) begin
         sel = 2'd0;
         if (bus.ALUOp_i == 3'd0 && bus.funct_i == 6'd16) sel = 2'd1;
         if (bus.ALUOp_i == 3'd0 && bus.funct_i == 6'd18) sel = 2'd2;
         st = (m_left > 0) && (is_md(bus.valid_i, bus.ALUOp_i, bus.funct_i) ||
                               is_hl(bus.valid_i, bus.ALUOp_i, bus.funct_i));
         chk("alu_ctrl", 64'(bus.ALUCtrl_o), 64'(ref_ctrl(bus.ALUOp_i, bus.funct_i)));
         chk("hilo_sel", 64'(bus.hilo_sel_o), 64'(sel));
         chk("stall", 64'(bus.stall_o), 64'(st));
         chk("busy", 64'(bus.busy_o), 64'(m_left > 0));
         chk("done", 64'(bus.done_o), 64'(m_done));
         chk("div_zero", 64'(bus.div_zero_o), 64'(m_dz));
         chk("hi", 64'(bus.hi_o), 64'(m_hi));
         chk("lo", 64'(bus.lo_o), 64'(m_lo));
         for (int i = 0; i < pin_n; i++) chk(pin_nm[i], pin_act[i], pin_exp[i]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      pin_n = 0;
   endtask

   task automatic pin(input string nm, input logic [63:0] a, input logic [63:0] e);
      if (pin_n < 8) begin
         pin_nm[pin_n] = nm; pin_act[pin_n] = a; pin_exp[pin_n] = e;
         pin_n++;
      end
   endtask

   // hold an R-type instruction until it is accepted (not stalled at an edge)
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int ns, output logic [31:0] lo_at, output logic [1:0] sel_at);
      bit ok;
      ok = 0; ns = 0; lo_at = '0; sel_at = '0;
      bus.valid_i = 1'b1; bus.ALUOp_i = 3'd0; bus.funct_i = f;
      bus.rs_data_i = a; bus.rt_data_i = b;
      for (int i = 0; i < 200 && !ok; i++) begin
         #1;
         if (!bus.stall_o) begin
            ok = 1; lo_at = bus.lo_o; sel_at = bus.hilo_sel_o;
         end else ns++;
         tick();
      end
      if (!ok) pin("issue_timeout", 64'(bus.stall_o), 64'd0);
      bus.valid_i = 1'b0;
      bus.funct_i = 6'd0;
   endtask

   task automatic wait_done(output int nb);
      bit ok;
      ok = 0; nb = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.done_o) ok = 1;
         else begin
            if (bus.busy_o) nb++;
            tick();
         end
      end
      if (!ok) pin("done_timeout", 64'(bus.done_o), 64'd1);
   endtask

   task automatic dec(input string nm, input logic [2:0] op, input logic [5:0] f, input logic [3:0] e);
      bus.ALUOp_i = op; bus.funct_i = f;
      #1;
      pin(nm, 64'(bus.ALUCtrl_o), 64'(e));
      tick();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int ns, nb, k;
      logic [31:0] la, lo_before;
      logic [1:0] sa;
      logic [5:0] fl [16];
      fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd2, 6'd6,
             6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27};
      bus.valid_i = 1'b0; bus.ALUOp_i = 3'd0; bus.funct_i = 6'd0;
      bus.rs_data_i = '0; bus.rt_data_i = '0;
      tick(); tick();
      pin("rst_busy", 64'(bus.busy_o), 64'd0);
      pin("rst_hi", 64'(bus.hi_o), 64'd0);
      pin("rst_lo", 64'(bus.lo_o), 64'd0);
      rst = 1'b0;
      tick();

      dec("dec_sub", 3'd0, 6'd34, 4'd6);
      dec("dec_nor", 3'd0, 6'd39, 4'd12);
      dec("dec_default", 3'd0, 6'd63, 4'd2);
      dec("dec_lui", 3'd4, 6'd0, 4'd5);
      dec("dec_bne", 3'd6, 6'd0, 4'd6);

      issue(6'd24, 32'hFFFF_FFFD, 32'd7, ns, la, sa);
      wait_done(nb);
      pin("mult_busy_len", 64'(nb), 64'd33);
      pin("mult_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
      pin("mult_lo", 64'(bus.lo_o), 64'hFFFF_FFEB);
      tick();
      pin("done_one_pulse", 64'(bus.done_o), 64'd0);
      issue(6'd25, 32'hFFFF_FFFD, 32'd7, ns, la, sa);
      wait_done(nb);
      pin("multu_hi", 64'(bus.hi_o), 64'h6);
      pin("multu_lo", 64'(bus.lo_o), 64'hFFFF_FFEB);
      tick();

      issue(6'd26, 32'hFFFF_FFF9, 32'd2, ns, la, sa);
      wait_done(nb);
      pin("div_lo", 64'(bus.lo_o), 64'hFFFF_FFFD);
      pin("div_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
      tick();
      issue(6'd27, 32'd7, 32'd0, ns, la, sa);
      wait_done(nb);
      pin("divz_lo", 64'(bus.lo_o), 64'hFFFF_FFFF);
      pin("divz_hi", 64'(bus.hi_o), 64'd7);
      pin("divz_flag", 64'(bus.div_zero_o), 64'd1);
      tick();
      issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, ns, la, sa);
      wait_done(nb);
      pin("minneg1_lo", 64'(bus.lo_o), 64'h8000_0000);
      pin("minneg1_hi", 64'(bus.hi_o), 64'd0);
      tick();

      issue(6'd24, 32'd5, 32'd9, ns, la, sa);
      issue(6'd18, 32'd0, 32'd0, ns, la, sa);
      pin("mflo_stalls", 64'(ns), 64'd33);
      pin("mflo_value", 64'(la), 64'd45);
      pin("mflo_sel", 64'(sa), 64'd2);
      tick();
      issue(6'd24, 32'd3, 32'd4, ns, la, sa);
      issue(6'd24, 32'd6, 32'd7, ns, la, sa);
      pin("b2b_stalls", 64'(ns), 64'd33);
      wait_done(nb);
      pin("b2b_lo", 64'(bus.lo_o), 64'd42);
      tick();

      issue(6'd25, 32'd1000, 32'd1000, ns, la, sa);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pin("abort_busy", 64'(bus.busy_o), 64'd0);
      pin("abort_hi", 64'(bus.hi_o), 64'd0);
      pin("abort_lo", 64'(bus.lo_o), 64'd0);
      pin("abort_done", 64'(bus.done_o), 64'd0);
      tick();
      issue(6'd27, 32'd100, 32'd7, ns, la, sa);
      wait_done(nb);
      pin("divu_lo", 64'(bus.lo_o), 64'd14);
      pin("divu_hi", 64'(bus.hi_o), 64'd2);
      tick();

      issue(6'd17, 32'hA5A5_A5A5, 32'd0, ns, la, sa);
      pin("mthi", 64'(bus.hi_o), 64'hA5A5_A5A5);
      lo_before = bus.lo_o;
      tick();
      issue(6'd24, 32'd2, 32'd3, ns, la, sa);
      bus.valid_i = 1'b1; bus.funct_i = 6'd19; bus.rs_data_i = 32'h1234_5678;
      #1;
      pin("mtlo_stall", 64'(bus.stall_o), 64'd1);
      tick();
      pin("mtlo_held", 64'(bus.lo_o), 64'(lo_before));
      issue(6'd19, 32'h1234_5678, 32'd0, ns, la, sa);
      pin("mtlo_after", 64'(bus.lo_o), 64'h1234_5678);
      tick();

      for (int c = 0; c < 2000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         bus.valid_i = ($urandom_range(0, 3) != 0);
         bus.ALUOp_i = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         k = $urandom_range(0, 16);
         bus.funct_i = (k < 16) ? fl[k] : 6'($urandom);
         bus.rs_data_i = pick();
         bus.rt_data_i = pick();
         tick();
      end
      rst = 1'b0;
      bus.valid_i = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
